// File: rtl/nios2os_pio_pkg.sv
// Shared register offsets and edge-type encodings for the nios2os PIO input capture block.
package nios2os_pio_pkg;

    localparam logic [1:0] PIO_DATA_OFS    = 2'd0;
    localparam logic [1:0] PIO_IRQMASK_OFS = 2'd2;
    localparam logic [1:0] PIO_EDGECAP_OFS = 2'd3;

    typedef enum logic [1:0] {
        PIO_EDGE_RISE = 2'd0,
        PIO_EDGE_FALL = 2'd1,
        PIO_EDGE_ANY  = 2'd2
    } pio_edge_e;

    // Arm counter value at which edge detection is enabled.
    localparam logic [1:0] PIO_ARM_DONE = 2'd3;

endpackage

// File: rtl/nios2os_pio_sync_edge.sv
// Two-flop input synchronizer, previous-value stage, arm counter and per-bit edge detector.
module nios2os_pio_sync_edge
    import nios2os_pio_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter int EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_q,
    output logic [WIDTH-1:0] edge_pulse
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_prev;
    logic [1:0]       r_arm;
    logic [WIDTH-1:0] w_edge;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_prev <= '0;
            r_arm  <= '0;
        end else begin
            r_s1   <= in_port;
            r_s2   <= r_s1;
            r_prev <= r_s2;
            if (r_arm != PIO_ARM_DONE) begin
                r_arm <= r_arm + 2'd1;
            end
        end
    end

    always_comb begin
        w_edge = r_s2 & ~r_prev;
        if (EDGE_TYPE == int'(PIO_EDGE_FALL)) begin
            w_edge = ~r_s2 & r_prev;
        end else if (EDGE_TYPE == int'(PIO_EDGE_ANY)) begin
            w_edge = r_s2 ^ r_prev;
        end
    end

    // Held off until the pipeline has refilled, so a line high through reset is not an edge.
    assign edge_pulse = (r_arm == PIO_ARM_DONE) ? w_edge : '0;
    assign sync_q     = r_s2;

endmodule

// File: rtl/nios2os_pio_in_capture.sv
// Avalon-MM input PIO with sticky W1C edge capture; IRQMASK and irq exist only when
// NIOS2OS_PIO_IRQ_EN is defined, otherwise software polls EDGECAPTURE.
module nios2os_pio_in_capture
    import nios2os_pio_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter int EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    logic [31:0]      r_readdata;
    logic [31:0]      w_rdmux;
    logic             w_wr;
    logic             w_rd;
    logic             w_unused_wdata;

    nios2os_pio_sync_edge #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_sync_edge (
        .clk        (clk),
        .reset      (reset),
        .in_port    (in_port),
        .sync_q     (w_sync),
        .edge_pulse (w_edge)
    );

    assign w_wr           = chipselect & ~write_n;
    assign w_rd           = chipselect & ~read_n;
    assign w_clr          = (w_wr && address == PIO_EDGECAP_OFS) ? writedata[WIDTH-1:0] : '0;
    assign w_unused_wdata = ^writedata;

    // Set after clear: a new edge survives a same-cycle W1C.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_edgecap <= '0;
        end else begin
            r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
        end
    end

`ifdef NIOS2OS_PIO_IRQ_EN
    logic [WIDTH-1:0] r_irqmask;
    logic             r_irq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irqmask <= '0;
            r_irq     <= 1'b0;
        end else begin
            if (w_wr && address == PIO_IRQMASK_OFS) begin
                r_irqmask <= writedata[WIDTH-1:0];
            end
            r_irq <= |(r_edgecap & r_irqmask);
        end
    end

    assign w_irqmask = r_irqmask;
    assign irq       = r_irq;
`else
    assign w_irqmask = '0;
    assign irq       = 1'b0;
`endif

    always_comb begin
        w_rdmux = '0;
        unique case (address)
            PIO_DATA_OFS:    w_rdmux[WIDTH-1:0] = w_sync;
            PIO_IRQMASK_OFS: w_rdmux[WIDTH-1:0] = w_irqmask;
            PIO_EDGECAP_OFS: w_rdmux[WIDTH-1:0] = r_edgecap;
            default:         w_rdmux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= '0;
        end else if (w_rd) begin
            r_readdata <= w_rdmux;
        end
    end

    assign readdata = r_readdata;

endmodule

// File: tb/tb_nios2os_pio_in_capture.sv
// Bench for nios2os_pio_in_capture: three WIDTH=4 instances (rising, falling, any edge) on one shared bus.
module tb_nios2os_pio_in_capture;

`ifdef NIOS2OS_PIO_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    typedef struct {
        logic [3:0]  inp;
        logic        rd;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] r_rise;
        logic [31:0] r_fall;
        logic [31:0] r_any;
        logic [2:0]  eirq;   // {any, fall, rise}
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] rdata [3];
    logic        irqv  [3];

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] sb [$];
    logic [31:0] held [3];
    vec_t        tbl [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        nios2os_pio_in_capture #(
            .WIDTH     (4),
            .EDGE_TYPE (g)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .address    (address),
            .chipselect (chipselect),
            .read_n     (read_n),
            .write_n    (write_n),
            .writedata  (writedata),
            .readdata   (rdata[g]),
            .in_port    (in_port),
            .irq        (irqv[g])
        );
    end

    function automatic vec_t mk(input logic [3:0] inp, input logic rd, input logic wr,
                                input logic [1:0] addr, input logic [31:0] wdata,
                                input logic [31:0] r0, input logic [31:0] r1,
                                input logic [31:0] r2, input logic [2:0] eirq);
        vec_t v;
        v.inp = inp; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.r_rise = r0; v.r_fall = r1; v.r_any = r2; v.eirq = eirq;
        return v;
    endfunction

    task automatic check(input string tag, input string what, input int d,
                         input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s %s dut%0d: got 0x%0h, expected 0x%0h", tag, what, d, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        in_port    = v.inp;
        chipselect = v.rd | v.wr;
        read_n     = ~v.rd;
        write_n    = ~v.wr;
        address    = v.addr;
        writedata  = v.wdata;
        if (v.rd) begin
            sb.push_back(v.r_rise);
            sb.push_back(v.r_fall);
            sb.push_back(v.r_any);
        end
        @(posedge clk);
        #1;
        if (v.rd) begin
            for (int d = 0; d < 3; d++) held[d] = sb.pop_front();
        end
        for (int d = 0; d < 3; d++) begin
            check(tag, "readdata", d, rdata[d], held[d]);
            check(tag, "irq", d, {31'd0, irqv[d]}, {31'd0, v.eirq[d] & IRQ_EN});
        end
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] m1;
        logic [31:0] m4;
        logic [31:0] m8;
        m1 = IRQ_EN ? 32'h1 : 32'h0;
        m4 = IRQ_EN ? 32'h4 : 32'h0;
        m8 = IRQ_EN ? 32'h8 : 32'h0;

        // Main table: in, rd, wr, addr, wdata, rd_rise, rd_fall, rd_any, irq{any,fall,rise}
        tbl.push_back(mk(4'hF, 0, 0, 2'd0, 32'h0, 0, 0, 0, 3'b000));
        tbl.push_back(mk(4'hF, 0, 0, 2'd0, 32'h0, 0, 0, 0, 3'b000));
        tbl.push_back(mk(4'hF, 0, 0, 2'd0, 32'h0, 0, 0, 0, 3'b000));
        tbl.push_back(mk(4'hF, 1, 0, 2'd0, 32'h0, 32'hF, 32'hF, 32'hF, 3'b000));
        tbl.push_back(mk(4'hF, 1, 0, 2'd3, 32'h0, 0, 0, 0, 3'b000));
        tbl.push_back(mk(4'hF, 0, 1, 2'd2, 32'h1, 0, 0, 0, 3'b000));
        tbl.push_back(mk(4'hF, 1, 0, 2'd2, 32'h0, m1, m1, m1, 3'b000));
        tbl.push_back(mk(4'hE, 0, 0, 2'd0, 32'h0, 0, 0, 0, 3'b000));
        tbl.push_back(mk(4'hE, 0, 0, 2'd0, 32'h0, 0, 0, 0, 3'b000));
        tbl.push_back(mk(4'hE, 1, 0, 2'd3, 32'h0, 0, 0, 0, 3'b000));
        tbl.push_back(mk(4'hE, 1, 0, 2'd3, 32'h0, 0, 1, 1, 3'b110));
        tbl.push_back(mk(4'hF, 1, 0, 2'd0, 32'h0, 32'hE, 32'hE, 32'hE, 3'b110));
        tbl.push_back(mk(4'hF, 0, 1, 2'd3, 32'h1, 0, 0, 0, 3'b110));
        tbl.push_back(mk(4'hF, 0, 0, 2'd0, 32'h0, 0, 0, 0, 3'b000));
        tbl.push_back(mk(4'hF, 1, 0, 2'd3, 32'h0, 1, 0, 1, 3'b101));
        tbl.push_back(mk(4'hF, 1, 0, 2'd0, 32'h0, 32'hF, 32'hF, 32'hF, 3'b101));
        tbl.push_back(mk(4'hF, 0, 1, 2'd3, 32'hF, 0, 0, 0, 3'b101));
        tbl.push_back(mk(4'hF, 0, 0, 2'd0, 32'h0, 0, 0, 0, 3'b000));
        tbl.push_back(mk(4'hF, 1, 0, 2'd3, 32'h0, 0, 0, 0, 3'b000));
        tbl.push_back(mk(4'hF, 1, 0, 2'd1, 32'h0, 0, 0, 0, 3'b000));
        tbl.push_back(mk(4'hF, 0, 1, 2'd1, 32'hFFFF_FFFF, 0, 0, 0, 3'b000));
        tbl.push_back(mk(4'hF, 1, 0, 2'd1, 32'h0, 0, 0, 0, 3'b000));
        tbl.push_back(mk(4'hF, 0, 1, 2'd0, 32'h0, 0, 0, 0, 3'b000));
        tbl.push_back(mk(4'hF, 1, 0, 2'd0, 32'h0, 32'hF, 32'hF, 32'hF, 3'b000));

        reset      = 1'b1;
        in_port    = 4'hF;
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = 32'h0;
        for (int d = 0; d < 3; d++) held[d] = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check("reset", "readdata", d, rdata[d], 32'h0);
            check("reset", "irq", d, {31'd0, irqv[d]}, 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Set/clear collision on bit 2: W1C lands on the same edge as a new rising capture.
        apply(mk(4'hF, 0, 1, 2'd2, 32'h4, 0, 0, 0, 3'b000), "coll_mask");
        apply(mk(4'hB, 0, 0, 2'd0, 32'h0, 0, 0, 0, 3'b000), "coll_fall0");
        apply(mk(4'hB, 0, 0, 2'd0, 32'h0, 0, 0, 0, 3'b000), "coll_fall1");
        apply(mk(4'hB, 0, 0, 2'd0, 32'h0, 0, 0, 0, 3'b000), "coll_fall2");
        apply(mk(4'hF, 0, 0, 2'd0, 32'h0, 0, 0, 0, 3'b110), "coll_rise0");
        apply(mk(4'hF, 0, 0, 2'd0, 32'h0, 0, 0, 0, 3'b110), "coll_rise1");
        apply(mk(4'hF, 0, 1, 2'd3, 32'h4, 0, 0, 0, 3'b110), "coll_w1c");
        apply(mk(4'hF, 1, 0, 2'd3, 32'h0, 32'h4, 32'h0, 32'h4, 3'b101), "coll_rd");
        apply(mk(4'hF, 1, 0, 2'd2, 32'h0, m4, m4, m4, 3'b101), "coll_rdmask");

        // Masking: bit-3 capture with IRQMASK=0, then unmask.
        apply(mk(4'hF, 0, 1, 2'd3, 32'hF, 0, 0, 0, 3'b101), "mask_clr");
        apply(mk(4'hF, 0, 1, 2'd2, 32'h0, 0, 0, 0, 3'b000), "mask_zero");
        apply(mk(4'h7, 0, 0, 2'd0, 32'h0, 0, 0, 0, 3'b000), "mask_fall0");
        apply(mk(4'h7, 0, 0, 2'd0, 32'h0, 0, 0, 0, 3'b000), "mask_fall1");
        apply(mk(4'h7, 0, 0, 2'd0, 32'h0, 0, 0, 0, 3'b000), "mask_fall2");
        apply(mk(4'hF, 0, 0, 2'd0, 32'h0, 0, 0, 0, 3'b000), "mask_rise0");
        apply(mk(4'hF, 0, 0, 2'd0, 32'h0, 0, 0, 0, 3'b000), "mask_rise1");
        apply(mk(4'hF, 0, 0, 2'd0, 32'h0, 0, 0, 0, 3'b000), "mask_rise2");
        apply(mk(4'hF, 1, 0, 2'd3, 32'h0, 32'h8, 32'h8, 32'h8, 3'b000), "mask_rdcap");
        apply(mk(4'hF, 0, 1, 2'd2, 32'h8, 0, 0, 0, 3'b000), "mask_set");
        apply(mk(4'hF, 0, 0, 2'd0, 32'h0, 0, 0, 0, 3'b111), "mask_irq");
        apply(mk(4'hF, 1, 0, 2'd2, 32'h0, m8, m8, m8, 3'b111), "mask_rd");

        // Asynchronous reset between clock edges, input held high, then re-arm.
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            check("async_rst", "readdata", d, rdata[d], 32'h0);
            check("async_rst", "irq", d, {31'd0, irqv[d]}, 32'h0);
            held[d] = 32'h0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        apply(mk(4'hF, 0, 0, 2'd0, 32'h0, 0, 0, 0, 3'b000), "rearm0");
        apply(mk(4'hF, 0, 0, 2'd0, 32'h0, 0, 0, 0, 3'b000), "rearm1");
        apply(mk(4'hF, 0, 0, 2'd0, 32'h0, 0, 0, 0, 3'b000), "rearm2");
        apply(mk(4'hF, 0, 0, 2'd0, 32'h0, 0, 0, 0, 3'b000), "rearm3");
        apply(mk(4'hF, 1, 0, 2'd3, 32'h0, 0, 0, 0, 3'b000), "rearm_cap");
        apply(mk(4'hF, 1, 0, 2'd0, 32'h0, 32'hF, 32'hF, 32'hF, 3'b000), "rearm_data");
        apply(mk(4'hF, 1, 0, 2'd2, 32'h0, 0, 0, 0, 3'b000), "rearm_mask");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nios2os_pio_in_capture.md
# nios2os_pio_in_capture

Avalon-MM slave input port with edge capture and interrupt: the read-side counterpart of the single-bit output PIOs that drive LCD control lines in the nios2os Qsys system. It samples external status lines such as LCD busy/ready or touch-panel IRQ through a synchronizer and latches selected edges into a sticky, write-one-to-clear capture register. It raises a maskable interrupt to the Nios II core. It sits on the same Avalon-MM data-master interconnect as the output PIOs.

## Interface
- `WIDTH`, default 1: number of input lines, 1..32.
- `EDGE_TYPE`, default 0: captured edge; 0 = rising, 1 = falling, 2 = any.
- `clk` input, 1 bit: the only clock; all logic is on its rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `address` input, 2 bits: register word select.
- `chipselect` input, 1 bit: Avalon slave select.
- `read_n` input, 1 bit: active-low read strobe.
- `write_n` input, 1 bit: active-low write strobe.
- `writedata` input, 32 bits: write data.
- `readdata` output, 32 bits: registered read data; bits above `WIDTH-1` read 0.
- `in_port` input, `WIDTH` bits: asynchronous external lines.
- `irq` output, 1 bit: level interrupt, active-high.

## Operation
- Synchronizer: `in_port` passes through `s1`, then `s2`. A third stage, `prev`, holds the previous value of `s2`. All three reset to 0.
- Edge detect per bit:
  - Rising: `s2 & ~prev`.
  - Falling: `~s2 & prev`.
  - Any: `s2 ^ prev`.
- Arm counter: a 2-bit counter is cleared by reset and increments each cycle until it saturates at 3. While it is below 3, edge detection is forced to 0. This suppresses the spurious edge that would otherwise come from an input held high through reset.
- Register map (word addresses):
  - 0: DATA. Read-only, returns `s2`. Writes are ignored.
  - 1: reserved. Reads 0; writes are ignored.
  - 2: IRQMASK. Read/write, low `WIDTH` bits.
  - 3: EDGECAPTURE. Read returns the sticky captured edges. A write clears every bit where `writedata` is 1.
- A write access is `chipselect & ~write_n`. A read access is `chipselect & ~read_n`.
- Capture update per bit: next value = (current value & ~clear) | detected edge. If a set and a clear hit the same bit in the same cycle, the set wins.
- `irq` = OR-reduce(EDGECAPTURE & IRQMASK), driven from a register.

## Timing
- Reset values: `readdata` = 0, `irq` = 0, all internal registers = 0.
- Read latency is 1 cycle: `readdata` is registered on the cycle of the read strobe and is valid the following cycle. It holds its value when no read is in progress. There are no wait states.
- Writes take effect on the clock edge at which the write strobe is sampled.
- Input to DATA: a change on `in_port` before edge N is visible in `s2` after edge N+1. A read issued on cycle N+2 returns the new value.
- Input to capture: a qualifying change before edge N sets EDGECAPTURE at edge N+2 and raises `irq` at edge N+3.
- A W1C write at edge N clears `irq` at edge N+1, unless a new edge is captured in the same cycle.
- Reset asserted mid-operation clears all state immediately, including the arm counter. `irq` drops without waiting for a clock edge.
- A read and a W1C to EDGECAPTURE cannot occur in the same cycle, since they are separate Avalon transfers. A read returns the value before any same-cycle set.

## Configuration
- Macro `NIOS2OS_PIO_IRQ_EN`.
- Defined: the IRQMASK register and the `irq` logic are present exactly as described above.
- Undefined: IRQMASK reads 0 and ignores writes, and `irq` is tied to 0. EDGECAPTURE and DATA still behave normally, so software polls EDGECAPTURE.

## Structure
- Shared package `nios2os_pio_pkg`:
  - Register offsets `PIO_DATA_OFS` = 0, `PIO_IRQMASK_OFS` = 2, `PIO_EDGECAP_OFS` = 3.
  - Edge encodings `PIO_EDGE_RISE`, `PIO_EDGE_FALL`, `PIO_EDGE_ANY`.
- One sub-module, `nios2os_pio_sync_edge`: the synchronizer, the arm counter and the edge detector, parameterised by `WIDTH` and `EDGE_TYPE`. It outputs `sync_q` and `edge_pulse`.
- The top level holds the register file, the read mux and the irq logic.

## Test plan
- Reset behaviour, `WIDTH`=4, `EDGE_TYPE`=0: hold `in_port`=4'hF through reset and release. After release, DATA reads 0xF, EDGECAPTURE stays 0 and `irq` stays 0.
- Capture latency: set IRQMASK=0x1, then drive bit 0 from 0 to 1 before edge N. EDGECAPTURE bit 0 sets at edge N+2 and `irq` rises at edge N+3.
- Clear and edge type: write 0x1 to address 3 and check that `irq` falls the next cycle. Drive bit 0 from 1 to 0 and check that there is no capture with `EDGE_TYPE`=0. Repeat with `EDGE_TYPE`=1 and check that bit 0 sets.
- Set/clear collision: W1C of bit 2 in the same cycle as a new bit-2 edge. The bit remains 1 and `irq` stays high.
- Masking: capture on bit 3 with IRQMASK=0 gives `irq`=0. Writing IRQMASK=0x8 makes `irq`=1 on the next cycle. Reads of address 1 return 0.
- Macro off: build without `NIOS2OS_PIO_IRQ_EN` and write IRQMASK=0xF. IRQMASK reads 0, edges are still captured, and `irq` is always 0.
